// File: rtl/flash_sched.sv
// rtl/flash_sched.sv - shares the SPI config flash between two read requesters and the JTAG bridge
// Issues reads to flash_read, tracks completion through its cs_b, and grants JTAG the pins only between reads.
module flash_sched #(
  parameter int ADDR_W     = 24,
  parameter int LEN_W      = 13,
  parameter int START_WAIT = 4,
  parameter int TIMEOUT_W  = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [LEN_W-1:0]  len0,
  input  logic [LEN_W-1:0]  len1,
  output logic              ack0,
  output logic              ack1,
  output logic              done0,
  output logic              done1,
  output logic              err,
  input  logic              jtag_req,
  output logic              jtag_gnt,
  output logic              spi_sel,
  output logic              fr_trigger,
  output logic [ADDR_W-1:0] fr_addr,
  output logic [LEN_W-1:0]  fr_len,
  input  logic              fr_cs_b,
  output logic              busy
);

  localparam int SC_W = $clog2(START_WAIT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_WAIT_START, S_BUSY, S_JTAG, S_GUARD
  } state_t;

  state_t            state_q, state_d;
  logic              rr_q, rr_d;
  logic              cur_q, cur_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [SC_W-1:0]   start_cnt_q, start_cnt_d;
  logic [TIMEOUT_W-1:0] wd_q, wd_d;
  logic              guard_q, guard_d;
  logic              done0_q, done0_d;
  logic              done1_q, done1_d;
  logic              err_q, err_d;
  logic              spi_sel_q, spi_sel_d;
  logic              jtag_gnt_q, jtag_gnt_d;

  logic              pick1, ack0_c, ack1_c, finish, fail;
  logic [ADDR_W-1:0] sel_addr;
  logic [LEN_W-1:0]  sel_len;

  always_comb begin
    // rr_q holds the requester served last; on a tie the other one wins
    pick1       = req1 & (~req0 | ~rr_q);
    sel_addr    = pick1 ? addr1 : addr0;
    sel_len     = pick1 ? len1 : len0;
    state_d     = state_q;
    rr_d        = rr_q;
    cur_d       = cur_q;
    addr_d      = addr_q;
    len_d       = len_q;
    start_cnt_d = start_cnt_q;
    wd_d        = wd_q;
    guard_d     = guard_q;
    done0_d     = 1'b0;
    done1_d     = 1'b0;
    err_d       = 1'b0;
    ack0_c      = 1'b0;
    ack1_c      = 1'b0;
    finish      = 1'b0;
    fail        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (jtag_req) begin
          state_d = S_JTAG;
        end else if (req0 | req1) begin
          ack0_c = ~pick1;
          ack1_c = pick1;
          cur_d  = pick1;
          if (sel_len != '0) begin
            addr_d  = sel_addr;
            len_d   = sel_len;
            state_d = S_LAUNCH;
          end else begin
            done0_d = ~pick1;
            done1_d = pick1;
            rr_d    = pick1;
          end
        end
      end
      S_LAUNCH: begin
        start_cnt_d = '0;
        wd_d        = '0;
        state_d     = S_WAIT_START;
      end
      S_WAIT_START: begin
        if (!fr_cs_b) begin
          state_d = S_BUSY;
        end else if (start_cnt_q == SC_W'(START_WAIT - 1)) begin
          finish = 1'b1;
          fail   = 1'b1;
        end else begin
          start_cnt_d = start_cnt_q + SC_W'(1);
        end
      end
      S_BUSY: begin
        if (fr_cs_b) begin
          finish = 1'b1;
        end else if (wd_q == {TIMEOUT_W{1'b1}}) begin
          finish = 1'b1;
          fail   = 1'b1;
        end else begin
          wd_d = wd_q + TIMEOUT_W'(1);
        end
      end
      S_JTAG: begin
        guard_d = 1'b0;
        if (!jtag_req) state_d = S_GUARD;
      end
      S_GUARD: begin
        if (guard_q) state_d = S_IDLE;
        else         guard_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    if (finish) begin
      state_d = S_IDLE;
      rr_d    = cur_q;
      done0_d = ~cur_q;
      done1_d = cur_q;
      err_d   = fail;
    end
    spi_sel_d  = (state_d == S_JTAG);
    jtag_gnt_d = (state_d == S_JTAG);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rr_q        <= 1'b1;
      cur_q       <= 1'b0;
      addr_q      <= '0;
      len_q       <= '0;
      start_cnt_q <= '0;
      wd_q        <= '0;
      guard_q     <= 1'b0;
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
      err_q       <= 1'b0;
      spi_sel_q   <= 1'b0;
      jtag_gnt_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      cur_q       <= cur_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      start_cnt_q <= start_cnt_d;
      wd_q        <= wd_d;
      guard_q     <= guard_d;
      done0_q     <= done0_d;
      done1_q     <= done1_d;
      err_q       <= err_d;
      spi_sel_q   <= spi_sel_d;
      jtag_gnt_q  <= jtag_gnt_d;
    end
  end

  // acks are combinational from IDLE; hold them off while reset is asserted
  assign ack0       = ack0_c & ~rst;
  assign ack1       = ack1_c & ~rst;
  assign done0      = done0_q;
  assign done1      = done1_q;
  assign err        = err_q;
  assign jtag_gnt   = jtag_gnt_q;
  assign spi_sel    = spi_sel_q;
  assign fr_trigger = (state_q == S_LAUNCH);
  assign fr_addr    = addr_q;
  assign fr_len     = len_q;
  assign busy       = (state_q != S_IDLE);

endmodule
